// File: rtl/pe_pkg.sv
// Shared PE definitions: operand geometry, accumulate-mode encodings
// and the feeder state enum.
package pe_pkg;

    localparam int DW   = 8;
    localparam int TAPS = 9;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_HOLD
    } feed_state_t;

endpackage

// File: rtl/pe_feeder_wdog.sv
// WAIT-state watchdog: counts enabled cycles, flags the TIMEOUT-th one.
// Built only when PE_FEEDER_TIMEOUT_EN is defined.
module pe_feeder_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    // expired is high during the TIMEOUT-th enabled cycle
    assign expired = start && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Streams a 3x3 window/filter pair into a PE tap by tap and holds the result.
// Optional WAIT timeout enabled by defining PE_FEEDER_TIMEOUT_EN.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int DW      = pe_pkg::DW,
    parameter int TAPS    = pe_pkg::TAPS,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAPS*DW-1:0] win_data,
    input  logic [TAPS*DW-1:0] flt_data,
    output logic [DW-1:0]     pe_in,
    output logic [DW-1:0]     pe_filter,
    output logic [1:0]        mode_o,
    input  logic [DW-1:0]     pe_out,
    input  logic              single_count_9,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,
    output logic              err
);

    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

    feed_state_t         state;
    logic [KW-1:0]       k;
    logic [KW-1:0]       k_next;
    logic [TAPS*DW-1:0]  win_r;
    logic [TAPS*DW-1:0]  flt_r;
    logic                last_tap;
    logic                wd_expired;

    assign in_ready = (state == ST_IDLE) && !rst;
    assign k_next   = k + 1'b1;
    assign last_tap = (k == KW'(TAPS - 1));

`ifdef PE_FEEDER_TIMEOUT_EN
    pe_feeder_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .start   (state == ST_WAIT),
        .clear   (state != ST_WAIT),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = (TIMEOUT != 0) || wd_expired;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            win_r     <= '0;
            flt_r     <= '0;
            pe_in     <= '0;
            pe_filter <= '0;
            mode_o    <= MODE_IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
`ifdef PE_FEEDER_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        // tap 0 goes out straight from the input bus
                        win_r     <= win_data;
                        flt_r     <= flt_data;
                        k         <= '0;
                        pe_in     <= win_data[DW-1:0];
                        pe_filter <= flt_data[DW-1:0];
                        mode_o    <= MODE_ACC;
                        state     <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (last_tap) begin
                        pe_in     <= '0;
                        pe_filter <= '0;
                        state     <= ST_WAIT;
                    end else begin
                        k         <= k_next;
                        pe_in     <= win_r[DW*k_next +: DW];
                        pe_filter <= flt_r[DW*k_next +: DW];
                    end
                end
                ST_WAIT: begin
                    if (single_count_9) begin
                        res_data  <= pe_out;
                        res_valid <= 1'b1;
                        mode_o    <= MODE_IDLE;
                        state     <= ST_HOLD;
`ifdef PE_FEEDER_TIMEOUT_EN
                        err       <= 1'b0;
                    end else if (wd_expired) begin
                        res_data  <= '0;
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        mode_o    <= MODE_IDLE;
                        state     <= ST_HOLD;
`endif
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        k         <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder with a behavioural PE model
// and a sum-of-products reference.
module tb_pe_feeder;

    localparam int DW   = 8;
    localparam int TAPS = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TAPS*DW-1:0] win_data = '0;
    logic [TAPS*DW-1:0] flt_data = '0;
    logic [DW-1:0]     pe_in;
    logic [DW-1:0]     pe_filter;
    logic [1:0]        mode_o;
    logic [DW-1:0]     pe_out = '0;
    logic              single_count_9 = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [DW-1:0]     res_data;
    logic              err;

    int checks = 0;
    int errors = 0;

    int pe_delay = 1;
    bit spur     = 1'b0;
    int pe_cnt   = 0;
    int pe_acc   = 0;

    typedef struct {
        logic [TAPS*DW-1:0] win;
        logic [TAPS*DW-1:0] flt;
        int                 d;
        int                 hold;
        logic [DW-1:0]      res;
    } vec_t;

    vec_t tbl[6];

    pe_feeder #(.DW(DW), .TAPS(TAPS), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .win_data       (win_data),
        .flt_data       (flt_data),
        .pe_in          (pe_in),
        .pe_filter      (pe_filter),
        .mode_o         (mode_o),
        .pe_out         (pe_out),
        .single_count_9 (single_count_9),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .err            (err)
    );

    always #5 clk = ~clk;

    // PE model: multiplies whatever is driven while accumulating and
    // flags completion pe_delay cycles after the 9th product.
    always @(negedge clk) begin
        single_count_9 = 1'b0;
        if (rst || mode_o != 2'b01) begin
            pe_cnt = 0;
            pe_acc = 0;
        end else begin
            pe_cnt = pe_cnt + 1;
            pe_acc = pe_acc + int'(pe_in) * int'(pe_filter);
        end
        pe_out = 8'(pe_acc);
        if (!rst && mode_o == 2'b01 && pe_cnt == 9 + pe_delay) begin
            single_count_9 = 1'b1;
        end else if (spur && (mode_o != 2'b01 || pe_cnt <= 9)
                     && $urandom_range(0, 3) == 0) begin
            single_count_9 = 1'b1;
            pe_out = 8'($urandom);
        end
    end

    function automatic logic [TAPS*DW-1:0] rnd72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[TAPS*DW-1:0];
    endfunction

    function automatic logic [TAPS*DW-1:0] fill(input logic [DW-1:0] v);
        logic [TAPS*DW-1:0] r;
        for (int k = 0; k < TAPS; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] conv(input logic [TAPS*DW-1:0] w,
                                           input logic [TAPS*DW-1:0] f);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < TAPS; k++)
            s = s + 32'(w[k*DW +: DW]) * 32'(f[k*DW +: DW]);
        return s[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic feed(input logic [TAPS*DW-1:0] w,
                        input logic [TAPS*DW-1:0] f, input int ntaps);
        @(negedge clk);
        chk("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        win_data = w;
        flt_data = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        win_data = rnd72();
        flt_data = rnd72();
        for (int k = 0; k < ntaps; k++) begin
            @(negedge clk);
            chk("feed_tap", {pe_in, pe_filter, mode_o, in_ready, res_valid},
                {w[k*DW +: DW], f[k*DW +: DW], 2'b01, 1'b0, 1'b0});
        end
    endtask

    task automatic run_window(input logic [TAPS*DW-1:0] w,
                              input logic [TAPS*DW-1:0] f,
                              input int d, input int hold,
                              input logic [DW-1:0] exp_res,
                              input logic exp_err, input int exp_wait);
        int  waited;
        bit  got;
        int  bad;
        pe_delay = d;
        feed(w, f, TAPS);
        waited = 0;
        got    = 1'b0;
        bad    = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            waited++;
            if (pe_in != 0 || pe_filter != 0 || mode_o != 2'b01 || in_ready)
                bad++;
        end
        chk("wait_outputs", 32'(bad), 32'd0);
        chk("wait_len", {31'(waited), got}, {31'(exp_wait), 1'b1});
        chk("result", {res_data, err, mode_o, pe_in, pe_filter, in_ready},
            {exp_res, exp_err, 2'b00, 8'd0, 8'd0, 1'b0});
        in_valid = 1'b1;
        win_data = rnd72();
        flt_data = rnd72();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_stable", {res_valid, res_data, err, in_ready, mode_o},
                {1'b1, exp_res, exp_err, 1'b0, 2'b00});
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("after_handshake", {res_valid, in_ready, mode_o}, {1'b0, 1'b1, 2'b00});
    endtask

    initial begin
        int vcnt;
        logic [TAPS*DW-1:0] w;
        logic [TAPS*DW-1:0] f;
        int d;

        tbl[0] = '{fill(8'd1),   fill(8'd1),   1, 0, 8'd9};
        tbl[1] = '{'0,           fill(8'd1),   2, 1, 8'd45};
        tbl[2] = '{fill(8'd16),  fill(8'd2),   3, 0, 8'd32};
        tbl[3] = '{'0,           fill(8'd2),   1, 5, 8'd90};
        tbl[4] = '{fill(8'd255), fill(8'd255), 4, 2, 8'd9};
        tbl[5] = '{'0,           rnd72(),      2, 1, 8'd0};
        for (int k = 0; k < TAPS; k++) begin
            tbl[1].win[k*DW +: DW] = 8'(k + 1);
            tbl[3].win[k*DW +: DW] = 8'(k + 1);
        end

        in_valid = 1'b1;
        #2;
        chk("reset_outputs",
            {in_ready, pe_in, pe_filter, mode_o, res_valid, res_data, err},
            32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset",
            {in_ready, pe_in, pe_filter, mode_o, res_valid, res_data, err},
            {1'b1, 8'd0, 8'd0, 2'b00, 1'b0, 8'd0, 1'b0});

        spur = 1'b1;
        foreach (tbl[i]) begin
            run_window(tbl[i].win, tbl[i].flt, tbl[i].d, tbl[i].hold,
                       tbl[i].res, 1'b0, tbl[i].d);
        end

        for (int i = 0; i < 20; i++) begin
            w = rnd72();
            f = rnd72();
            d = $urandom_range(1, 5);
            run_window(w, f, d, $urandom_range(0, 3), conv(w, f), 1'b0, d);
        end

        // reset while tap 4 is on the PE
        spur = 1'b0;
        pe_delay = 2;
        feed(rnd72(), rnd72(), 5);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_feed_reset", {pe_in, pe_filter, mode_o, in_ready, res_valid},
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_release_ready", 32'(in_ready), 32'd1);
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid || mode_o != 2'b00) vcnt++;
        end
        chk("no_partial_result", 32'(vcnt), 32'd0);
        w = rnd72();
        f = rnd72();
        run_window(w, f, 2, 1, conv(w, f), 1'b0, 2);

        // PE never signals completion
        w = rnd72();
        f = rnd72();
`ifdef PE_FEEDER_TIMEOUT_EN
        run_window(w, f, 1 << 20, 1, 8'd0, 1'b1, 16);
`else
        pe_delay = 1 << 20;
        feed(w, f, TAPS);
        vcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid || mode_o != 2'b01) vcnt++;
        end
        chk("no_timeout_stays_wait", 32'(vcnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("recover_ready", {in_ready, res_valid, err}, {1'b1, 1'b0, 1'b0});
`endif
        w = rnd72();
        f = rnd72();
        run_window(w, f, 1, 0, conv(w, f), 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter DW, 8, data width of every PE operand and result.
REQ-002 Parameter TAPS, 9, operand pairs streamed per window.
REQ-003 Parameter TIMEOUT, 16, WAIT-state cycle limit (used only under PE_FEEDER_TIMEOUT_EN).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  window/filter pair offered.
REQ-007 in_ready  output  1  feeder accepts a pair this cycle.
REQ-008 win_data  input  TAPS*DW  3x3 window; tap k = bits [DW*k+DW-1 : DW*k].
REQ-009 flt_data  input  TAPS*DW  3x3 filter; same tap packing.
REQ-010 pe_in  output  DW  operand to PE input port.
REQ-011 pe_filter  output  DW  operand to PE filter port.
REQ-012 mode_o  output  2  PE accumulate control; 2'b00 idle, 2'b01 accumulate.
REQ-013 pe_out  input  DW  PE accumulated result.
REQ-014 single_count_9  input  1  PE flag; result on pe_out is final this cycle.
REQ-015 res_valid  output  1  result held for consumer.
REQ-016 res_ready  input  1  consumer accepts result.
REQ-017 res_data  output  DW  captured convolution result.
REQ-018 err  output  1  result produced by timeout; valid with res_valid.

Function
REQ-019 FSM states IDLE, FEED, WAIT, HOLD; in_ready SHALL equal (state==IDLE).
REQ-020 IDLE->FEED on in_valid&&in_ready; win_data and flt_data SHALL be registered that edge; tap index k cleared to 0.
REQ-021 FEED: pe_in=win tap k, pe_filter=flt tap k, mode_o=2'b01, k increments each cycle; first tap driven cycle after acceptance, tap 8 on the 9th cycle.
REQ-022 FEED->WAIT on the cycle after k==TAPS-1 is driven; no gaps, no repeats.
REQ-023 WAIT: pe_in=pe_filter=0, mode_o=2'b01; on single_count_9==1 capture pe_out into res_data, err=0, go HOLD.
REQ-024 single_count_9 in IDLE, FEED or HOLD SHALL be ignored.
REQ-025 HOLD: res_valid=1, mode_o=2'b00; res_data/err stable until res_valid&&res_ready, then IDLE.
REQ-026 Outside FEED, pe_in and pe_filter SHALL be 0; mode_o=2'b00 in IDLE and HOLD.
REQ-027 Result SHALL pass pe_out unmodified (mod-2^DW wrap owned by PE; no saturation).
REQ-028 in_valid in any non-IDLE state SHALL be ignored and not lost from the producer (in_ready=0).
REQ-029 Minimum accept-to-accept interval: 9 FEED + WAIT latency + 1 HOLD + 1 IDLE cycle.

Reset
REQ-030 rst asserted at any time SHALL force IDLE, k=0, and outputs to: in_ready=0 during rst then 1, pe_in=0, pe_filter=0, mode_o=2'b00, res_valid=0, res_data=0, err=0.
REQ-031 Reset mid-FEED/WAIT/HOLD SHALL abort the window; no partial result emitted.

Configuration
REQ-032 Macro PE_FEEDER_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT cycles without single_count_9, go HOLD with res_data=0, err=1.
REQ-033 Macro undefined: WAIT lasts until single_count_9, no counter synthesized, err tied 0.

Structure
REQ-034 Shared package pe_pkg SHALL hold DW, TAPS, mode encodings (MODE_IDLE, MODE_ACC) and the feeder state enum.
REQ-035 WAIT timeout counter SHALL be sub-module pe_feeder_wdog (start, clear, expired), instantiated only under PE_FEEDER_TIMEOUT_EN.

Verification
REQ-036 All taps win=1, flt=1, PE model asserts count at 9th product -> pe_in/pe_filter show 1 for 9 consecutive cycles, res_data=9, err=0.
REQ-037 win taps 1..9, flt all 1 -> pe_in sequence 1,2,...,9 in tap order, res_data=45.
REQ-038 win all 16, flt all 2 -> res_data=32 (288 mod 256).
REQ-039 res_ready held 0 for 5 cycles in HOLD -> res_valid=1, res_data stable, in_ready=0, second in_valid not accepted until handshake.
REQ-040 rst pulsed while k==4 -> next cycle pe_in=0, mode_o=2'b00, res_valid never asserts for that window; fresh window then completes normally.
REQ-041 PE_FEEDER_TIMEOUT_EN, single_count_9 held 0 -> res_valid after 16 WAIT cycles with res_data=0, err=1; without macro, res_valid stays 0.
